// File: rtl/gray_rr_arbiter.sv
// gray_rr_arbiter
//   Round-robin arbiter sharing one DW-bit output channel among NR valid/ready
//   requesters, with one registered output stage. Each output beat carries the
//   binary index of its source and that index's Gray code.
//
//   Optional feature: define GRAY_ARB_LOCK_EN to enable burst lock. In this
//   mode a beat with in_last=0 keeps the grant on its requester until a beat
//   with in_last=1 ends the burst.
//
// Parameters
//   NR : number of requesters (2 <= NR <= 2**KW)
//   KW : index / select width
//   DW : data width per requester
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   per-requester valid
//   in_data    requester i occupies [DW*i +: DW]
//   in_last    per-requester end-of-burst marker
//   in_ready   per-requester ready (combinational, one-hot or zero)
//   out_valid  output beat valid
//   out_data   granted data
//   out_id     binary index of the source requester
//   out_gray   Gray code of out_id
//   out_last   registered in_last of the source requester
//   out_ready  downstream accept
module gray_rr_arbiter #(
   parameter int unsigned NR = 4,
   parameter int unsigned KW = 2,
   parameter int unsigned DW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NR-1:0]    in_valid,
   input  logic [NR*DW-1:0] in_data,
   input  logic [NR-1:0]    in_last,
   output logic [NR-1:0]    in_ready,
   output logic             out_valid,
   output logic [DW-1:0]    out_data,
   output logic [KW-1:0]    out_id,
   output logic [KW-1:0]    out_gray,
   output logic             out_last,
   input  logic             out_ready
);

   logic [KW-1:0] ptr;
   logic [KW-1:0] w_srch;
   logic [KW-1:0] w;
   logic [KW-1:0] w_inc;
   logic          found;
   logic          load;
   logic          any_v;
   logic          xfer;
   logic          adv;
   int unsigned   idx;
   logic [KW-1:0] idx_k;

   assign load  = !out_valid || out_ready;
   assign any_v = |in_valid;

   // Search starts at ptr and wraps at NR rather than at 2**KW, so the
   // winner is always a legal requester index.
   always_comb begin
      w_srch = '0;
      found  = 1'b0;
      idx    = 0;
      idx_k  = '0;
      for (int unsigned off = 0; off < NR; off++) begin
         idx = int'(ptr) + off;
         if (idx >= NR) idx = idx - NR;
         idx_k = KW'(idx);
         if (!found && in_valid[idx_k]) begin
            w_srch = idx_k;
            found  = 1'b1;
         end
      end
   end

`ifdef GRAY_ARB_LOCK_EN
   typedef enum logic {OPEN, LOCKED} lock_t;
   lock_t         state;
   lock_t         state_nxt;
   logic [KW-1:0] lock_id;
   logic [KW-1:0] lock_id_nxt;

   // While LOCKED the grant stays on lock_id even if that requester is idle,
   // so no other requester can slip a beat into the middle of a burst.
   assign w   = (state == LOCKED) ? lock_id : w_srch;
   assign adv = in_last[w];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= OPEN;
         lock_id <= '0;
      end else begin
         state   <= state_nxt;
         lock_id <= lock_id_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      lock_id_nxt = lock_id;
      if (xfer) begin
         if (in_last[w]) begin
            state_nxt = OPEN;
         end else begin
            state_nxt   = LOCKED;
            lock_id_nxt = w;
         end
      end
   end
`else
   assign w   = w_srch;
   assign adv = 1'b1;
`endif

   assign w_inc    = (w == KW'(NR - 1)) ? '0 : w + 1'b1;
   assign in_ready = (load && any_v && !rst) ? (NR'(1) << w) : '0;
   assign xfer     = |(in_ready & in_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         out_gray  <= '0;
         out_last  <= 1'b0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[DW*w +: DW];
         out_id    <= w;
         out_gray  <= w ^ (w >> 1);
         out_last  <= in_last[w];
         if (adv) ptr <= w_inc;
      end else if (load) begin
         // Nothing transferred this cycle (idle, or locked requester idle):
         // the register is free, so present a bubble instead of a repeat.
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gray_rr_arbiter.sv
module tb_gray_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_id;
   logic [1:0]  out_gray;
   logic        out_last;
   logic        out_ready;

   int ntests = 0;
   int nfail  = 0;

   gray_rr_arbiter #(.NR(4), .KW(2), .DW(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
      .out_gray(out_gray), .out_last(out_last), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic v, input logic [1:0] id,
                       input logic [1:0] g, input logic [7:0] d, input logic l);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".id"},    32'(out_id),    32'(id));
      chk({tag, ".gray"},  32'(out_gray),  32'(g));
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".last"},  32'(out_last),  32'(l));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 4'b0000;
      in_data   = {8'hA5, 8'h32, 8'h21, 8'h10};
      in_last   = 4'b1111;
      out_ready = 1'b1;
      tick; tick;
      outs("reset", 1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
      in_valid = 4'b1111;
      #1 chk("reset.in_ready", 32'(in_ready), 32'h0);
      in_valid = 4'b0000;
      rst = 1'b0;

      // idle
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("idle.in_ready", 32'(in_ready), 32'h0);
         outs("idle", 1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
      end

      // all requesting: full rotation, one beat per cycle
      in_valid = 4'b1111;
      #1 chk("rot.ready0", 32'(in_ready), 32'b0001);
      tick; outs("rot0", 1'b1, 2'd0, 2'd0, 8'h10, 1'b1);
      chk("rot.ready1", 32'(in_ready), 32'b0010);
      tick; outs("rot1", 1'b1, 2'd1, 2'd1, 8'h21, 1'b1);
      tick; outs("rot2", 1'b1, 2'd2, 2'd3, 8'h32, 1'b1);
      tick; outs("rot3", 1'b1, 2'd3, 2'd2, 8'hA5, 1'b1);
      tick; outs("rot4", 1'b1, 2'd0, 2'd0, 8'h10, 1'b1);
      in_valid = 4'b0000;
      tick; chk("rot.drain", 32'(out_valid), 32'h0);

      // reset to ptr 0, then sparse requesters 1 and 3
      rst = 1'b1; tick; rst = 1'b0;
      in_valid = 4'b1010;
      #1 chk("sparse.ready0", 32'(in_ready), 32'b0010);
      tick; outs("sparse0", 1'b1, 2'd1, 2'd1, 8'h21, 1'b1);
      tick; outs("sparse1", 1'b1, 2'd3, 2'd2, 8'hA5, 1'b1);
      tick; outs("sparse2", 1'b1, 2'd1, 2'd1, 8'h21, 1'b1);
      in_valid = 4'b0000;
      tick; chk("sparse.drain", 32'(out_valid), 32'h0);

      // backpressure: ptr=2, requester 0 loads, then held for 3 cycles
      in_valid = 4'b0001;
      tick; outs("bp.load", 1'b1, 2'd0, 2'd0, 8'h10, 1'b1);
      out_ready = 1'b0;
      in_valid  = 4'b0110;
      #1 chk("bp.ready", 32'(in_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick;
         outs("bp.hold", 1'b1, 2'd0, 2'd0, 8'h10, 1'b1);
         chk("bp.hold.ready", 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1 chk("bp.release.ready", 32'(in_ready), 32'b0010);
      tick; outs("bp.refill", 1'b1, 2'd1, 2'd1, 8'h21, 1'b1);
      in_valid = 4'b0000;
      tick; chk("bp.drain", 32'(out_valid), 32'h0);

      // burst from requester 2 (ptr=2) with requester 0 also valid
      in_valid = 4'b0101;
      in_last  = 4'b0001;
`ifdef GRAY_ARB_LOCK_EN
      tick; outs("lock0", 1'b1, 2'd2, 2'd3, 8'h32, 1'b0);
      chk("lock.ready", 32'(in_ready), 32'b0100);
      tick; outs("lock1", 1'b1, 2'd2, 2'd3, 8'h32, 1'b0);
      in_last = 4'b0101;
      tick; outs("lock2", 1'b1, 2'd2, 2'd3, 8'h32, 1'b1);
      in_valid = 4'b0001;
      tick; outs("lock3", 1'b1, 2'd0, 2'd0, 8'h10, 1'b1);
`else
      tick; outs("nolock0", 1'b1, 2'd2, 2'd3, 8'h32, 1'b0);
      tick; outs("nolock1", 1'b1, 2'd0, 2'd0, 8'h10, 1'b1);
      tick; outs("nolock2", 1'b1, 2'd2, 2'd3, 8'h32, 1'b0);
      tick; outs("nolock3", 1'b1, 2'd0, 2'd0, 8'h10, 1'b1);
`endif
      in_valid = 4'b0000;
      in_last  = 4'b1111;
      tick; chk("burst.drain", 32'(out_valid), 32'h0);

      // reset while a beat from requester 3 is held (ptr=1)
      in_valid = 4'b1000;
      tick; outs("mid.pre", 1'b1, 2'd3, 2'd2, 8'hA5, 1'b1);
      rst      = 1'b1;
      in_valid = 4'b1010;
      #1 chk("mid.rst.ready", 32'(in_ready), 32'h0);
      tick; outs("mid.rst", 1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
      rst = 1'b0;
      #1 chk("mid.after.ready", 32'(in_ready), 32'b0010);
      tick; outs("mid.first", 1'b1, 2'd1, 2'd1, 8'h21, 1'b1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
